// File: rtl/duty_slew_ctrl.sv
// duty_slew_ctrl: accepts a target duty level over valid/ready and slews the
// registered duty reference one LSB at a time toward it, stepping only on PWM
// counter wraps so the downstream comparator never sees a mid-period change.
// tgt_rate sets how many wraps pass between steps (rate+1 wraps per step).
module duty_slew_ctrl #(
   parameter int WIDTH  = 6,
   parameter int RATE_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pwm_wrap,
   input  logic              tgt_valid,
   output logic              tgt_ready,
   input  logic [WIDTH-1:0]  tgt_level,
   input  logic [RATE_W-1:0] tgt_rate,
   output logic [WIDTH-1:0]  duty,
   output logic              busy,
   output logic              done
);

   typedef enum logic {
      IDLE = 1'b0,
      SLEW = 1'b1
   } state_t;

   state_t            state;
   logic [WIDTH-1:0]  tgt_q;
   logic [RATE_W-1:0] rate_q;
   logic [RATE_W-1:0] div_cnt;
   logic [WIDTH-1:0]  step_duty;
   logic              accept;

   // A new target is only taken while idle; requests during a slew are dropped.
   assign tgt_ready = !busy;
   assign accept    = tgt_valid && tgt_ready;

   // Candidate duty one LSB closer to the target; never overshoots.
   always_comb begin
      // NOTE: default assignment first so every path drives step_duty and no latch is inferred.
      step_duty = duty;
      if (tgt_q > duty) begin
         step_duty = duty + 1'b1;
      end else if (tgt_q < duty) begin
         step_duty = duty - 1'b1;
      end
   end

   // Handshake, wrap divider, duty stepping and completion pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         duty    <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         tgt_q   <= '0;
         rate_q  <= '0;
         div_cnt <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register updates from pre-edge values.
         done <= 1'b0;
         case (state)
            IDLE: begin
               // Accept wins over a coincident wrap; that wrap is not counted.
               if (accept) begin
                  tgt_q   <= tgt_level;
                  rate_q  <= tgt_rate;
                  div_cnt <= '0;
                  if (tgt_level == duty) begin
                     done <= 1'b1;
                  end else begin
                     state <= SLEW;
                     busy  <= 1'b1;
                  end
               end
            end
            SLEW: begin
               if (pwm_wrap) begin
                  // Equality test before increment keeps div_cnt from overflowing.
                  if (div_cnt == rate_q) begin
                     div_cnt <= '0;
                     duty    <= step_duty;
                     if (step_duty == tgt_q) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                     end
                  end else begin
                     div_cnt <= div_cnt + 1'b1;
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_duty_slew_ctrl.sv
// Directed bench for duty_slew_ctrl: reset, ramps at two rates, equal target,
// ignored request while busy, accept-with-wrap, full scale and reset mid-slew.
module tb_duty_slew_ctrl;

   localparam int WIDTH  = 6;
   localparam int RATE_W = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              pwm_wrap = 1'b0;
   logic              tgt_valid = 1'b0;
   logic              tgt_ready;
   logic [WIDTH-1:0]  tgt_level = '0;
   logic [RATE_W-1:0] tgt_rate = '0;
   logic [WIDTH-1:0]  duty;
   logic              busy;
   logic              done;

   int n_vec = 0;
   int n_err = 0;

   duty_slew_ctrl #(.WIDTH(WIDTH), .RATE_W(RATE_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .pwm_wrap  (pwm_wrap),
      .tgt_valid (tgt_valid),
      .tgt_ready (tgt_ready),
      .tgt_level (tgt_level),
      .tgt_rate  (tgt_rate),
      .duty      (duty),
      .busy      (busy),
      .done      (done)
   );

   // 10-unit clock; outputs are sampled on falling edges.
   always #5 clk = ~clk;

   // Watchdog so the run always terminates.
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, want summary before time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input int got, input int exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Wait out a PWM period with duty held at 'hold', then pulse pwm_wrap once.
   // Returns on the falling edge just after the wrap edge.
   task automatic wrap_pulse(input int hold);
      repeat (62) @(negedge clk);
      check("hold_between_wraps", int'(duty), hold);
      @(negedge clk);
      pwm_wrap = 1'b1;
      @(negedge clk);
      pwm_wrap = 1'b0;
   endtask

   // Present a target for one edge, optionally with a coincident wrap.
   task automatic request(input int level, input int rate, input bit with_wrap);
      tgt_valid = 1'b1;
      tgt_level = WIDTH'(level);
      tgt_rate  = RATE_W'(rate);
      pwm_wrap  = with_wrap;
      @(negedge clk);
      tgt_valid = 1'b0;
      pwm_wrap  = 1'b0;
   endtask

   initial begin
      // ---- reset held for 3 cycles ----
      repeat (3) @(negedge clk);
      check("rst_duty", int'(duty), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_ready", int'(tgt_ready), 1);
      rst = 1'b0;
      @(negedge clk);

      // ---- ramp up 0 -> 5, rate 0 ----
      request(5, 0, 1'b0);
      check("up_busy_on_accept", int'(busy), 1);
      check("up_ready_on_accept", int'(tgt_ready), 0);
      check("up_duty_on_accept", int'(duty), 0);
      for (int k = 1; k <= 5; k++) begin
         wrap_pulse(k - 1);
         check("up_duty", int'(duty), k);
         check("up_done", int'(done), (k == 5) ? 1 : 0);
         check("up_busy", int'(busy), (k == 5) ? 0 : 1);
      end
      @(negedge clk);
      check("up_done_clears", int'(done), 0);
      check("up_ready_after", int'(tgt_ready), 1);

      // ---- ramp down 5 -> 2, rate 2: steps on wraps 3, 6, 9 ----
      request(2, 2, 1'b0);
      for (int k = 1; k <= 9; k++) begin
         wrap_pulse(5 - (k - 1) / 3);
         check("dn_duty", int'(duty), 5 - k / 3);
         check("dn_done", int'(done), (k == 9) ? 1 : 0);
      end
      check("dn_busy_end", int'(busy), 0);

      // ---- equal target ----
      @(negedge clk);
      request(2, 0, 1'b0);
      check("eq_done", int'(done), 1);
      check("eq_busy", int'(busy), 0);
      check("eq_duty", int'(duty), 2);
      @(negedge clk);
      check("eq_done_clears", int'(done), 0);
      check("eq_busy_after", int'(busy), 0);

      // ---- slew 2 -> 20 with an ignored request mid-slew ----
      request(20, 0, 1'b0);
      for (int k = 1; k <= 18; k++) begin
         if (k == 6) begin
            tgt_valid = 1'b1;
            tgt_level = '0;
            tgt_rate  = '0;
            #1;
            check("busy_ready_low", int'(tgt_ready), 0);
            @(negedge clk);
            tgt_valid = 1'b0;
            check("busy_req_ignored_duty", int'(duty), 7);
            check("busy_req_ignored_busy", int'(busy), 1);
         end
         wrap_pulse(k + 1);
         check("to20_duty", int'(duty), k + 2);
      end
      check("to20_done", int'(done), 1);
      check("to20_busy", int'(busy), 0);
      @(negedge clk);

      // ---- accept coincident with a wrap: that wrap is not a step ----
      request(25, 0, 1'b1);
      check("accwrap_duty", int'(duty), 20);
      check("accwrap_busy", int'(busy), 1);
      for (int k = 1; k <= 5; k++) begin
         wrap_pulse(19 + k);
         check("accwrap_step", int'(duty), 20 + k);
      end
      check("accwrap_done", int'(done), 1);

      // ---- asynchronous reset pulse between edges ----
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("arst_duty", int'(duty), 0);
      check("arst_ready", int'(tgt_ready), 1);
      #1 rst = 1'b0;
      @(negedge clk);
      check("arst_duty_after", int'(duty), 0);

      // ---- full scale 0 -> 63, rate 0 ----
      request(63, 0, 1'b0);
      for (int k = 1; k <= 63; k++) begin
         wrap_pulse(k - 1);
         check("fs_duty", int'(duty), k);
      end
      check("fs_done", int'(done), 1);
      wrap_pulse(63);
      check("fs_no_wrap_around", int'(duty), 63);
      check("fs_idle_busy", int'(busy), 0);

      // ---- slew down, reset at duty 30 ----
      request(0, 0, 1'b0);
      for (int k = 1; k <= 33; k++) begin
         wrap_pulse(64 - k);
      end
      check("mid_duty_30", int'(duty), 30);
      check("mid_busy", int'(busy), 1);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_duty", int'(duty), 0);
      check("mid_rst_busy", int'(busy), 0);
      @(negedge clk);
      check("mid_rst_no_done", int'(done), 0);
      rst = 1'b0;
      request(10, 0, 1'b0);
      check("post_rst_accept_busy", int'(busy), 1);
      check("post_rst_accept_ready", int'(tgt_ready), 0);
      for (int k = 1; k <= 10; k++) begin
         wrap_pulse(k - 1);
         check("post_rst_duty", int'(duty), k);
      end
      check("post_rst_done", int'(done), 1);
      check("post_rst_busy", int'(busy), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/duty_slew_ctrl.md
# duty_slew_ctrl

Upstream stage of the PWM generator. Accepts a target duty level over a valid/ready handshake and slews its registered `duty` output one LSB at a time toward that target. Steps occur only on PWM period boundaries, so the downstream comparator never sees a mid-period duty change. The output replaces the raw switch value as the PWM reference and gives a programmable fade rate.

## Interface
Parameters:
- `WIDTH`, 6, duty/target width. The PWM counter period is 2^WIDTH clocks.
- `RATE_W`, 8, width of the rate field.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset. The top level drives it from the inverted `rst_n` pad.
- `pwm_wrap`  in  1  one-cycle pulse from the PWM generator when its counter wraps (counter == 2^WIDTH-1).
- `tgt_valid`  in  1  target request valid.
- `tgt_ready`  out  1  block can accept a target.
- `tgt_level`  in  WIDTH  requested duty, unsigned.
- `tgt_rate`  in  RATE_W  PWM periods per step, minus one. 0 means step on every wrap.
- `duty`  out  WIDTH  registered duty reference, unsigned.
- `busy`  out  1  slew in progress.
- `done`  out  1  one-cycle pulse when `duty` reaches the accepted target.

## Operation
- Two states:
  - IDLE: `tgt_ready=1`, `busy=0`.
  - SLEW: `tgt_ready=0`, `busy=1`.
- `tgt_ready` is combinational `!busy`. `busy` is registered.
- Accept rule: a target is accepted on a rising edge where `tgt_valid && tgt_ready`. On accept, `tgt_level` is latched to `tgt_q`, `tgt_rate` is latched to `rate_q`, and `div_cnt` is cleared to 0.
- Accept with `tgt_level == duty`:
  - State stays IDLE.
  - `done`=1 for the following cycle.
  - `busy` never asserts.
- Accept with `tgt_level != duty`: go to SLEW.
- SLEW, on an edge with `pwm_wrap=1`:
  - If `div_cnt == rate_q`: clear `div_cnt` to 0 and step `duty` by +1 (if `tgt_q > duty`) or -1 (if `tgt_q < duty`).
  - Otherwise: increment `div_cnt`.
- SLEW, on an edge with `pwm_wrap=0`: hold everything.
- Completion: if the new `duty` equals `tgt_q` on a step edge, the same edge moves the state to IDLE, clears `busy` and sets `done`=1. `done` clears on the next edge.
- Requests while SLEW: `tgt_valid` is ignored and not queued. No retargeting mid-slew.
- Acceptance and wrap on the same edge in IDLE: accept wins. That wrap is not counted, so the first step needs `rate_q+1` further wraps.
- Arithmetic:
  - Step is exactly ±1 and never over- or undershoots; `duty` stays within 0..2^WIDTH-1.
  - `div_cnt` is RATE_W bits and cannot overflow, because it is compared for equality with `rate_q` before incrementing.
- Steps needed: total wraps after accept = |target−start| × (rate+1).

## Timing
- Reset values, applied asynchronously while `rst`=1:
  - `duty`=0, `busy`=0, `done`=0, `tgt_ready`=1.
  - State IDLE; `div_cnt`, `tgt_q`, `rate_q` = 0.
- Reset asserted mid-slew: `duty` drops to 0 immediately, with no clock edge needed. There is no `done` pulse and the pending target is discarded.
- Reset deassert: first accept is possible on the first rising edge after `rst` falls.
- Latencies:
  - Accept to `busy`=1: 1 edge, on the accept edge itself.
  - Step edge to `duty` change: the same edge. `duty` is registered and changes only on edges where `pwm_wrap` is sampled high.
  - Final step: `done` high and `busy` low in the same cycle `duty` equals the target. `tgt_ready` is high that cycle, so back-to-back requests lose no cycles.

## Test plan
- Reset: hold `rst`=1 for 3 cycles → `duty`=0, `busy`=0, `done`=0, `tgt_ready`=1. Pulse `rst` asynchronously between edges → `duty` clears without a clock.
- Ramp up, rate 0: from `duty`=0, accept `tgt_level`=5, `tgt_rate`=0, then `pwm_wrap` every 64 clocks → `duty` goes 1,2,3,4,5 on wraps 1–5. `done` pulses once, with `duty`=5; `busy` low after.
- Ramp down, rate 2: from `duty`=5, accept target 2, rate 2 → `duty` 4,3,2 on wraps 3, 6 and 9; `done` on wrap 9. No change on any other edge.
- Equal target: accept target equal to current `duty` → `done`=1 on the next cycle, `busy` stays 0, `duty` unchanged.
- Request while busy, plus simultaneous events: during a slew to 20, assert `tgt_valid` with target 0 → `tgt_ready`=0, request ignored, slew still ends at 20. Separately, accept on an edge with `pwm_wrap`=1 and rate 0 → first step lands on the next wrap, not the accept edge.
- Full-scale and reset mid-operation: slew 0→63 with rate 0 → 63 wraps, `duty`=63, no wrap-around to 0. Repeat and assert `rst` at `duty`=30 → `duty`=0 immediately, no `done`; a new request for 10 is accepted on the first edge after release.
